// File: rtl/transpose_pkg.sv
// Shared types and helpers for the tile transpose controller.
package transpose_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic int unsigned tile_words(input int unsigned n);
    return n * n;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/transpose_tile_ctrl_if.sv
// Input stream, output stream and SRAM port of the transpose controller.
interface transpose_tile_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // master: the controller; slave: producer, consumer and SRAM around it
  modport master (
    input  in_valid, in_data, out_ready, mem_rdata,
    output in_ready, out_valid, out_data, out_last,
           mem_cs, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data, out_ready, mem_rdata,
    input  in_ready, out_valid, out_data, out_last,
           mem_cs, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/transpose_tile_ctrl_out_fifo2.sv
// Two-entry register FIFO holding {last, data} between SRAM read data and the output stream.
module out_fifo2 #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   occ,
  output logic [W-1:0] head
);
  logic [W-1:0] slot [2];
  logic         rd_ptr;
  logic         wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Payload needs no reset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    if (push) slot[wr_ptr] <= push_data;
  end

  assign head = slot[rd_ptr];
endmodule

// File: rtl/transpose_tile_ctrl.sv
// Writes an N x N tile row-major into a single-bank SRAM, then streams it back column-major.
module transpose_tile_ctrl
  import transpose_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  transpose_tile_ctrl_if.master bus,
  output logic                  tile_done,
  output logic                  busy
);
  localparam int unsigned WORDS = tile_words(N);
  localparam int unsigned CNT_W = cnt_width(N);

  if (N < 2) begin : g_bad_n
    $error("transpose_tile_ctrl: N must be >= 2");
  end
  if (WORDS > (64'd1 << ADDR_W)) begin : g_bad_addr
    $error("transpose_tile_ctrl: N*N exceeds SRAM address space");
  end

  state_t            state, state_next;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]  rd_row;
  logic [CNT_W-1:0]  rd_col;
  logic              pend;
  logic              pend_last;

  logic              in_ready;
  logic              wr;
  logic              rd_issue;
  logic              wr_at_end;
  logic              rd_at_end;
  logic              row_wrap;
  logic              pop;
  logic [1:0]        occ;
  logic [DATA_W:0]   head;

  assign wr_at_end = (wr_addr == ADDR_W'(WORDS - 1));
  assign row_wrap  = (rd_row == CNT_W'(N - 1));
  assign rd_at_end = row_wrap && (rd_col == CNT_W'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (wr && wr_at_end)       state_next = DRAIN;
      DRAIN:   if (rd_issue && rd_at_end) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // Issue only if the FIFO still has room once this read's data lands next cycle.
  always_comb begin
    in_ready      = (state == FILL) && !rst;
    wr            = bus.in_valid && in_ready;
    pop           = bus.out_valid && bus.out_ready;
    rd_issue      = (state == DRAIN) &&
                    (({1'b0, occ} + {2'b00, pend}) < (3'd2 + {2'b00, pop}));
    bus.in_ready  = in_ready;
    bus.mem_cs    = wr || rd_issue;
    bus.mem_we    = wr;
    bus.mem_addr  = wr ? wr_addr : rd_addr;
    bus.mem_wdata = bus.in_data;
    bus.out_valid = (occ != 2'd0);
    bus.out_data  = head[DATA_W-1:0];
    bus.out_last  = bus.out_valid && head[DATA_W];
    tile_done     = pop && head[DATA_W];
    busy          = (state == DRAIN) || (occ != 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr   <= '0;
      rd_addr   <= '0;
      rd_row    <= '0;
      rd_col    <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
    end else begin
      pend      <= rd_issue;
      pend_last <= rd_issue && rd_at_end;
      if (wr) wr_addr <= wr_at_end ? '0 : wr_addr + ADDR_W'(1);
      // Column-major walk: +N down a column, jump to the next column's top on row wrap.
      if (rd_issue) begin
        if (rd_at_end) begin
          rd_row  <= '0;
          rd_col  <= '0;
          rd_addr <= '0;
        end else if (row_wrap) begin
          rd_row  <= '0;
          rd_col  <= rd_col + CNT_W'(1);
          rd_addr <= ADDR_W'(rd_col) + ADDR_W'(1);
        end else begin
          rd_row  <= rd_row + CNT_W'(1);
          rd_addr <= rd_addr + ADDR_W'(N);
        end
      end
    end
  end

  out_fifo2 #(.W(DATA_W + 1)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pend),
    .push_data ({pend_last, bus.mem_rdata}),
    .pop       (pop),
    .occ       (occ),
    .head      (head)
  );
endmodule
